// File: rtl/execute_stage.sv
// execute_stage: 16-bit single-cycle ALU with a 16-step shift-add multiplier.
module execute_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_in,
    input  logic        flush_in,
    input  logic [2:0]  ALUop_in,
    input  logic [15:0] srcA_in,
    input  logic [15:0] srcB_in,
    input  logic        wbs_in,
    input  logic        mm_in,
    input  logic        wm_in,
    input  logic        am_in,
    input  logic        ni_in,
    input  logic        wme_in,
    output logic        stall_out,
    output logic        valid_out,
    output logic [15:0] alu_result_out,
    output logic [15:0] store_data_out,
    output logic        zero_out,
    output logic        neg_out,
    output logic        wbs_out,
    output logic        mm_out,
    output logic        wm_out,
    output logic        am_out,
    output logic        ni_out,
    output logic        wme_out
);
    typedef enum logic {IDLE, MUL_BUSY} state_t;
    state_t      state;
    logic [3:0]  cnt;
    logic [15:0] mul_a, mul_b, acc, acc_next, alu_res;
    logic [5:0]  ctrl_q, ctrl_in;
    logic        is_mul;
    assign is_mul  = ALUop_in == 3'b111;
    assign ctrl_in = {wbs_in, mm_in, wm_in, am_in, ni_in, wme_in};
    assign acc_next = acc + (mul_b[cnt] ? mul_a << cnt : 16'd0);
    // Released at the last step so upstream advances on the edge the product lands.
    assign stall_out = rst_n && !flush_in && (state == MUL_BUSY ? cnt != 4'd15 : valid_in && is_mul);
    always_comb begin
        alu_res = 16'd0;
        case (ALUop_in)
            3'b000: alu_res = srcA_in + srcB_in;
            3'b001: alu_res = srcA_in - srcB_in;
            3'b010: alu_res = srcA_in & srcB_in;
            3'b011: alu_res = srcA_in | srcB_in;
            3'b100: alu_res = srcA_in ^ srcB_in;
            3'b101: alu_res = srcA_in << srcB_in[3:0];
            3'b110: alu_res = srcA_in >> srcB_in[3:0];
            default: alu_res = 16'd0;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            mul_a          <= '0;
            mul_b          <= '0;
            acc            <= '0;
            ctrl_q         <= '0;
            valid_out      <= 1'b0;
            alu_result_out <= '0;
            store_data_out <= '0;
            zero_out       <= 1'b0;
            neg_out        <= 1'b0;
            {wbs_out, mm_out, wm_out, am_out, ni_out, wme_out} <= '0;
        end else if (flush_in) begin
            state     <= IDLE;
            cnt       <= '0;
            valid_out <= 1'b0;
        end else if (state == IDLE) begin
            if (valid_in && is_mul) begin
                mul_a     <= srcA_in;
                mul_b     <= srcB_in;
                acc       <= '0;
                ctrl_q    <= ctrl_in;
                cnt       <= '0;
                state     <= MUL_BUSY;
                valid_out <= 1'b0;
            end else begin
                valid_out <= valid_in;
                if (valid_in) begin
                    alu_result_out <= alu_res;
                    store_data_out <= srcB_in;
                    zero_out       <= alu_res == 16'd0;
                    neg_out        <= alu_res[15];
                    {wbs_out, mm_out, wm_out, am_out, ni_out, wme_out} <= ctrl_in;
                end
            end
        end else begin
            acc <= acc_next;
            cnt <= cnt + 4'd1;
            if (cnt == 4'd15) begin
                state          <= IDLE;
                valid_out      <= 1'b1;
                alu_result_out <= acc_next;
                store_data_out <= mul_b;
                zero_out       <= acc_next == 16'd0;
                neg_out        <= acc_next[15];
                {wbs_out, mm_out, wm_out, am_out, ni_out, wme_out} <= ctrl_q;
            end
        end
    end
endmodule
